spi_slave_multi: RTL and testbench

Parametrised multi-channel SPI slave receiver. It has NUM_CH parallel data lines sharing one SCK and one active-low SSEL, all oversampled in the clk domain. Each frame can carry any number of back-to-back WORD_W-bit words. Completed words are presented through a valid/ready holding register to the acquisition logic, with frame-error and overrun reporting.

---
 rtl/spi_slave_multi_if.sv | 41 ++++
 rtl/spi_slave_multi.sv | 190 +++++++++++++++++++
 tb/tb_spi_slave_multi.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_multi_if.sv
// Bus bundle for spi_slave_multi: SPI pins, receive holding register and status.
// The tx_data/miso pair exists only when SPI_MISO_EN is defined.
interface spi_slave_multi_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned WORD_W = 32
);
  localparam int unsigned CntW = $clog2(WORD_W);

  logic                     en;
  logic                     sck;
  logic                     ssel_n;
  logic [NUM_CH-1:0]        data_in;
  logic [NUM_CH*WORD_W-1:0] rx_data;
  logic                     rx_valid;
  logic                     rx_ready;
  logic                     frame_err;
  logic                     overrun;
  logic [CntW-1:0]          bit_cnt;
`ifdef SPI_MISO_EN
  logic [WORD_W-1:0]        tx_data;
  logic                     miso;

  modport slave (
    input  en, sck, ssel_n, data_in, rx_ready, tx_data,
    output rx_data, rx_valid, frame_err, overrun, bit_cnt, miso
  );
  modport master (
    output en, sck, ssel_n, data_in, rx_ready, tx_data,
    input  rx_data, rx_valid, frame_err, overrun, bit_cnt, miso
  );
`else
  modport slave (
    input  en, sck, ssel_n, data_in, rx_ready,
    output rx_data, rx_valid, frame_err, overrun, bit_cnt
  );
  modport master (
    output en, sck, ssel_n, data_in, rx_ready,
    input  rx_data, rx_valid, frame_err, overrun, bit_cnt
  );
`endif
endinterface

// File: rtl/spi_slave_multi.sv
// Multi-channel oversampled SPI slave receiver with valid/ready holding register.
// Define SPI_MISO_EN to add a transmit shift register driving miso from tx_data.
module spi_slave_multi #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          SAMPLE_RISE = 1'b1,
  parameter bit          MSB_FIRST   = 1'b1
) (
  input logic              clk,
  input logic              reset,
  spi_slave_multi_if.slave bus
);
  localparam int unsigned CntW = $clog2(WORD_W);

  logic [SYNC_STAGES-1:0]             r_sck_sync;
  logic [SYNC_STAGES-1:0]             r_ssel_sync;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] r_data_sync;
  logic                               r_sck_prev;
  logic                               r_ssel_prev;
  logic [SYNC_STAGES:0]               r_flush;
  logic                               r_armed;

  logic [CntW-1:0]                r_bit_cnt, w_bit_cnt_d;
  logic [NUM_CH-1:0][WORD_W-1:0]  r_shift, w_shift_d;
  logic                           r_done, w_done_d;
  logic                           r_ferr, w_ferr_d;
  logic [NUM_CH*WORD_W-1:0]       r_rx_data, w_rx_data_d;
  logic                           r_rx_valid, w_rx_valid_d;
  logic                           r_ovr, w_ovr_d;

  logic w_sck, w_sck_rise, w_sck_fall, w_sample;
  logic w_ssel_n, w_ssel_fall, w_ssel_rise;
  logic w_frame_start, w_active, w_abort, w_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_sync  <= '0;
      r_ssel_sync <= '1;
      r_data_sync <= '0;
      r_sck_prev  <= 1'b0;
      r_ssel_prev <= 1'b1;
      r_flush     <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.sck};
      r_ssel_sync <= {r_ssel_sync[SYNC_STAGES-2:0], bus.ssel_n};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], bus.data_in};
      r_sck_prev  <= w_sck;
      r_ssel_prev <= w_ssel_n;
      r_flush     <= {r_flush[SYNC_STAGES-1:0], 1'b1};
      // Only arm once real pin state shows ssel_n high, so a frame cut by reset stays ignored.
      if (r_flush[SYNC_STAGES] && w_ssel_n) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_sck         = r_sck_sync[SYNC_STAGES-1];
  assign w_sck_rise    = w_sck & ~r_sck_prev;
  assign w_sck_fall    = ~w_sck & r_sck_prev;
  assign w_sample      = SAMPLE_RISE ? w_sck_rise : w_sck_fall;
  assign w_ssel_n      = r_ssel_sync[SYNC_STAGES-1];
  assign w_ssel_fall   = ~w_ssel_n & r_ssel_prev;
  assign w_ssel_rise   = w_ssel_n & ~r_ssel_prev;
  assign w_frame_start = r_armed & w_ssel_fall;
  assign w_active      = r_armed & ~w_ssel_n & bus.en;
  assign w_abort       = w_ssel_rise | w_frame_start | ~bus.en | ~r_armed;
  assign w_last        = (r_bit_cnt == CntW'(WORD_W - 1));

  always_comb begin
    w_bit_cnt_d = r_bit_cnt;
    w_shift_d   = r_shift;
    w_done_d    = 1'b0;
    w_ferr_d    = 1'b0;
    if (w_abort) begin
      w_bit_cnt_d = '0;
      w_shift_d   = '0;
      w_ferr_d    = w_ssel_rise && (r_bit_cnt != '0);
    end else if (w_active && w_sample) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (MSB_FIRST) begin
          w_shift_d[k] = {r_shift[k][WORD_W-2:0], r_data_sync[SYNC_STAGES-1][k]};
        end else begin
          w_shift_d[k] = {r_data_sync[SYNC_STAGES-1][k], r_shift[k][WORD_W-1:1]};
        end
      end
      if (w_last) begin
        w_bit_cnt_d = '0;
        w_done_d    = 1'b1;
      end else begin
        w_bit_cnt_d = r_bit_cnt + CntW'(1);
      end
    end
  end

  // The shift registers still hold the finished word in the cycle after completion.
  always_comb begin
    w_rx_data_d  = r_rx_data;
    w_rx_valid_d = r_rx_valid;
    w_ovr_d      = 1'b0;
    if (r_rx_valid && bus.rx_ready) begin
      w_rx_valid_d = 1'b0;
    end
    if (r_done) begin
      if (!r_rx_valid || bus.rx_ready) begin
        w_rx_data_d  = r_shift;
        w_rx_valid_d = 1'b1;
      end else begin
        w_ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_done     <= 1'b0;
      r_ferr     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_bit_cnt  <= w_bit_cnt_d;
      r_shift    <= w_shift_d;
      r_done     <= w_done_d;
      r_ferr     <= w_ferr_d;
      r_rx_data  <= w_rx_data_d;
      r_rx_valid <= w_rx_valid_d;
      r_ovr      <= w_ovr_d;
    end
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_ferr;
  assign bus.overrun   = r_ovr;
  assign bus.bit_cnt   = r_bit_cnt;

`ifdef SPI_MISO_EN
  logic [WORD_W-1:0] r_tx, w_tx_d;
  logic              r_tx_pend, w_tx_pend_d;
  logic              r_tx_reload, w_tx_reload_d;
  logic              w_shift_edge;

  assign w_shift_edge = SAMPLE_RISE ? w_sck_fall : w_sck_rise;

  // After a word completes, the next non-sample edge loads the new word instead of shifting,
  // keeping the last bit on miso until the master is done with it.
  always_comb begin
    w_tx_d        = r_tx;
    w_tx_pend_d   = r_tx_pend;
    w_tx_reload_d = r_tx_reload;
    if (w_frame_start) begin
      w_tx_d        = bus.tx_data;
      w_tx_pend_d   = 1'b0;
      w_tx_reload_d = 1'b0;
    end else if (w_active && w_sample) begin
      if (w_last) begin
        w_tx_reload_d = 1'b1;
      end else begin
        w_tx_pend_d = 1'b1;
      end
    end else if (w_active && w_shift_edge) begin
      if (r_tx_reload) begin
        w_tx_d        = bus.tx_data;
        w_tx_reload_d = 1'b0;
      end else if (r_tx_pend) begin
        w_tx_d      = MSB_FIRST ? {r_tx[WORD_W-2:0], 1'b0} : {1'b0, r_tx[WORD_W-1:1]};
        w_tx_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx        <= '0;
      r_tx_pend   <= 1'b0;
      r_tx_reload <= 1'b0;
    end else begin
      r_tx        <= w_tx_d;
      r_tx_pend   <= w_tx_pend_d;
      r_tx_reload <= w_tx_reload_d;
    end
  end

  assign bus.miso = w_active & (MSB_FIRST ? r_tx[WORD_W-1] : r_tx[0]);
`endif
endmodule

// File: tb/tb_spi_slave_multi.sv
// Scoreboard bench for spi_slave_multi: a 2x32 rising/MSB-first instance and a
// 1x8 falling/LSB-first instance, driven with random words against a word-level model.
module tb_spi_slave_multi;
  localparam int PH = 4;
  localparam int SA = 2;
  localparam int SB = 3;
  localparam logic [31:0] TxWord = 32'hCAFEF00D;

  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  int ferr_a = 0, ovr_a = 0, ferr_b = 0, ovr_b = 0;
  int exp_ferr_a = 0, exp_ovr_a = 0;
  logic [63:0] qa[$];
  logic [63:0] qb[$];

  always #5 clk = ~clk;

  spi_slave_multi_if #(.NUM_CH(2), .WORD_W(32)) bus_a ();
  spi_slave_multi_if #(.NUM_CH(1), .WORD_W(8))  bus_b ();

  spi_slave_multi #(
    .NUM_CH(2), .WORD_W(32), .SYNC_STAGES(SA), .SAMPLE_RISE(1'b1), .MSB_FIRST(1'b1)
  ) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a.slave)
  );

  spi_slave_multi #(
    .NUM_CH(1), .WORD_W(8), .SYNC_STAGES(SB), .SAMPLE_RISE(1'b0), .MSB_FIRST(1'b0)
  ) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sck(input int d, input logic v);
    if (d == 0) bus_a.sck = v;
    else        bus_b.sck = v;
  endtask

  task automatic set_ssel(input int d, input logic v);
    if (d == 0) bus_a.ssel_n = v;
    else        bus_b.ssel_n = v;
  endtask

  task automatic set_ready(input int d, input logic v);
    if (d == 0) bus_a.rx_ready = v;
    else        bus_b.rx_ready = v;
  endtask

  // One SCK period: data set up, sample edge, hold, then back to idle (non-sample edge).
  task automatic send_bit(input int d, input logic [1:0] din, input bit chk, input logic expm,
                          input bit pulse);
    logic idle;
    idle = (d == 0) ? 1'b0 : 1'b1;
    if (d == 0) bus_a.data_in = din;
    else        bus_b.data_in = din[0];
    cyc(PH);
`ifdef SPI_MISO_EN
    if (d == 0 && chk) check("miso_setup", 64'(bus_a.miso), 64'(expm));
`endif
    set_sck(d, ~idle);
    if (pulse) begin
      cyc(((d == 0) ? SA : SB) + 1);
      set_ready(d, 1'b1);
      cyc(1);
      set_ready(d, 1'b0);
    end
    cyc(PH);
`ifdef SPI_MISO_EN
    if (d == 0 && chk) check("miso_hold", 64'(bus_a.miso), 64'(expm));
`endif
    set_sck(d, idle);
  endtask

  // w holds channel k in w[k*W +: W]; bits first..first+nbits-1 of the word are sent.
  task automatic send_word(input int d, input logic [63:0] w, input int first, input int nbits,
                           input bit chk, input int pulse_bit);
    int wid, nch, idx;
    logic [1:0] din;
    wid = (d == 0) ? 32 : 8;
    nch = (d == 0) ? 2 : 1;
    for (int i = first; i < first + nbits; i++) begin
      idx = (d == 0) ? (wid - 1 - i) : i;
      din = '0;
      for (int k = 0; k < nch; k++) din[k] = w[k * wid + idx];
      send_bit(d, din, chk, TxWord[31 - (i % 32)], (i == pulse_bit));
    end
  endtask

  task automatic start_frame(input int d);
    set_ssel(d, 1'b0);
    cyc(PH);
  endtask

  task automatic end_frame(input int d);
    cyc(PH);
    set_ssel(d, 1'b1);
    cyc(2 * PH + 6);
  endtask

  // Monitor: every accepted word set must match the next expected one, in order.
  initial begin
    forever begin
      @(negedge clk);
      if (bus_a.rx_valid && bus_a.rx_ready) begin
        if (qa.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_unexpected_word: got %0h, expected none", bus_a.rx_data);
        end else begin
          check("a_rx_data", 64'(bus_a.rx_data), qa.pop_front());
        end
      end
      if (bus_b.rx_valid && bus_b.rx_ready) begin
        if (qb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_unexpected_word: got %0h, expected none", bus_b.rx_data);
        end else begin
          check("b_rx_data", 64'(bus_b.rx_data), qb.pop_front());
        end
      end
      if (bus_a.frame_err) ferr_a++;
      if (bus_a.overrun)   ovr_a++;
      if (bus_b.frame_err) ferr_b++;
      if (bus_b.overrun)   ovr_b++;
    end
  end

  initial begin
    logic [63:0] w;
    int nw;
    reset = 1'b1;
    bus_a.en = 1'b1; bus_a.sck = 1'b0; bus_a.ssel_n = 1'b1; bus_a.data_in = '0;
    bus_a.rx_ready = 1'b0;
    bus_b.en = 1'b1; bus_b.sck = 1'b1; bus_b.ssel_n = 1'b1; bus_b.data_in = '0;
    bus_b.rx_ready = 1'b0;
`ifdef SPI_MISO_EN
    bus_a.tx_data = TxWord;
    bus_b.tx_data = '0;
`endif
    cyc(3);
    check("a_reset_valid", 64'(bus_a.rx_valid), 64'd0);
    check("a_reset_data", 64'(bus_a.rx_data), 64'd0);
    check("a_reset_bitcnt", 64'(bus_a.bit_cnt), 64'd0);
    check("a_reset_ferr", 64'(bus_a.frame_err), 64'd0);
    check("a_reset_ovr", 64'(bus_a.overrun), 64'd0);
    check("b_reset_valid", 64'(bus_b.rx_valid), 64'd0);
    check("b_reset_data", 64'(bus_b.rx_data), 64'd0);
`ifdef SPI_MISO_EN
    check("a_reset_miso", 64'(bus_a.miso), 64'd0);
`endif
    reset = 1'b0;
    cyc(10);

    // Single word, always ready.
    bus_a.rx_ready = 1'b1;
    w = {32'h12345678, 32'hDEADBEEF};
    qa.push_back(w);
    start_frame(0);
    send_word(0, w, 0, 32, 1'b1, -1);
    end_frame(0);
`ifdef SPI_MISO_EN
    check("a_idle_miso", 64'(bus_a.miso), 64'd0);
`endif

    // Three back-to-back words with the consumer stalled: first held, two dropped.
    bus_a.rx_ready = 1'b0;
    start_frame(0);
    for (int i = 1; i <= 3; i++) begin
      w = {$urandom(), 32'(i)};
      if (i == 1) qa.push_back(w);
      else        exp_ovr_a++;
      send_word(0, w, 0, 32, 1'b1, -1);
    end
    end_frame(0);
    check("a_overrun_count", 64'(ovr_a), 64'(exp_ovr_a));
    check("a_held_valid", 64'(bus_a.rx_valid), 64'd1);
    check("a_held_ch0", 64'(bus_a.rx_data[31:0]), 64'd1);
    bus_a.rx_ready = 1'b1;
    cyc(1);
    check("a_valid_cleared", 64'(bus_a.rx_valid), 64'd0);

    // Partial frame of 17 bits, then a clean frame.
    start_frame(0);
    w = {$urandom(), $urandom()};
    send_word(0, w, 0, 17, 1'b0, -1);
    exp_ferr_a++;
    end_frame(0);
    check("a_ferr_partial", 64'(ferr_a), 64'(exp_ferr_a));
    w = {$urandom(), 32'hA5A5A5A5};
    qa.push_back(w);
    start_frame(0);
    send_word(0, w, 0, 32, 1'b1, -1);
    end_frame(0);

    // Enable dropped at bit 10: silent abort.
    start_frame(0);
    w = {$urandom(), $urandom()};
    send_word(0, w, 0, 10, 1'b0, -1);
    bus_a.en = 1'b0;
    send_word(0, w, 10, 22, 1'b0, -1);
    end_frame(0);
    check("a_ferr_en_abort", 64'(ferr_a), 64'(exp_ferr_a));
    bus_a.en = 1'b1;
    cyc(2);
    w = {$urandom(), $urandom()};
    qa.push_back(w);
    start_frame(0);
    send_word(0, w, 0, 32, 1'b1, -1);
    end_frame(0);

    // Reset mid-frame: the rest of that frame must be ignored.
    start_frame(0);
    w = {$urandom(), $urandom()};
    send_word(0, w, 0, 5, 1'b0, -1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    send_word(0, w, 5, 27, 1'b0, -1);
    check("a_bitcnt_after_reset", 64'(bus_a.bit_cnt), 64'd0);
    end_frame(0);
    check("a_ferr_after_reset", 64'(ferr_a), 64'(exp_ferr_a));
    w = {$urandom(), $urandom()};
    qa.push_back(w);
    start_frame(0);
    send_word(0, w, 0, 32, 1'b1, -1);
    end_frame(0);

    // Random multi-word frames.
    for (int f = 0; f < 4; f++) begin
      nw = $urandom_range(1, 3);
      start_frame(0);
      for (int j = 0; j < nw; j++) begin
        w = {$urandom(), $urandom()};
        qa.push_back(w);
        send_word(0, w, 0, 32, 1'b1, -1);
      end
      end_frame(0);
    end

    // Falling-edge, LSB-first: 0x81, then a word whose load coincides with the accept.
    start_frame(1);
    w = 64'h81;
    qb.push_back(w);
    send_word(1, w, 0, 8, 1'b0, -1);
    w = 64'($urandom_range(0, 255));
    qb.push_back(w);
    send_word(1, w, 0, 8, 1'b0, 7);
    end_frame(1);
    check("b_valid_after_swap", 64'(bus_b.rx_valid), 64'd1);
    check("b_data_after_swap", 64'(bus_b.rx_data), w);
    bus_b.rx_ready = 1'b1;
    cyc(2);
    check("b_valid_drained", 64'(bus_b.rx_valid), 64'd0);
    start_frame(1);
    for (int j = 0; j < 2; j++) begin
      w = 64'($urandom_range(0, 255));
      qb.push_back(w);
      send_word(1, w, 0, 8, 1'b0, -1);
    end
    end_frame(1);

    cyc(20);
    check("a_queue_empty", 64'(qa.size()), 64'd0);
    check("b_queue_empty", 64'(qb.size()), 64'd0);
    check("a_ferr_total", 64'(ferr_a), 64'(exp_ferr_a));
    check("a_ovr_total", 64'(ovr_a), 64'(exp_ovr_a));
    check("b_ferr_total", 64'(ferr_b), 64'd0);
    check("b_ovr_total", 64'(ovr_b), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
